// File: rtl/ru_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// ru_write_arbiter_if
// Purpose : Bundles the writeback-side handshakes and the register-file write
//           port that the write arbiter sits between.
// Signals : clr                  - one-cycle request to re-run the zero sweep
//           v0/rd0/data0/rdy0    - requester 0 (ALU) valid/index/data/ready
//           v1/rd1/data1/rdy1    - requester 1 (load unit) valid/index/data/ready
//           rd/datawrite/Ruwr    - register file write index/data/enable
//           initdone             - high while the arbiter is serving requests
//           dropcnt              - saturating count of discarded x0 writes
// Modports: slave  - the arbiter's view
//           master - the view of the requesters and the register file
// ---------------------------------------------------------------------------
interface ru_write_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          clr;
   logic          v0;
   logic [AW-1:0] rd0;
   logic [DW-1:0] data0;
   logic          rdy0;
   logic          v1;
   logic [AW-1:0] rd1;
   logic [DW-1:0] data1;
   logic          rdy1;
   logic [AW-1:0] rd;
   logic [DW-1:0] datawrite;
   logic          Ruwr;
   logic          initdone;
   logic [7:0]    dropcnt;

   modport slave (
      input  clr, v0, rd0, data0, v1, rd1, data1,
      output rdy0, rdy1, rd, datawrite, Ruwr, initdone, dropcnt
   );

   modport master (
      output clr, v0, rd0, data0, v1, rd1, data1,
      input  rdy0, rdy1, rd, datawrite, Ruwr, initdone, dropcnt
   );
endinterface

// File: rtl/ru_write_arbiter.sv
// ---------------------------------------------------------------------------
// ru_write_arbiter
// Purpose : Owns the single write port of the register file. After reset, or
//           on a clr pulse, it zero-fills registers 0..NREGS-1. It then
//           shares the port between two writeback requesters using
//           round-robin arbitration. Writes to x0 are accepted but
//           suppressed, and they are counted.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - ru_write_arbiter_if.slave (requesters + write port)
// ---------------------------------------------------------------------------
module ru_write_arbiter #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ru_write_arbiter_if.slave     bus
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                r_state;
   logic   [AW-1:0]       r_cnt;
   logic   [AW-1:0]       r_rd;
   logic   [DW-1:0]       r_datawrite;
   logic                  r_ruwr;
   logic                  r_lastg;
   logic   [7:0]          r_dropcnt;

   logic                  w_run;
   logic                  w_g0;
   logic                  w_g1;
   logic                  w_hs0;
   logic                  w_hs1;

   // Under contention, the requester that did not win last time is served.
   assign w_g0  = bus.v0 && (!bus.v1 || r_lastg);
   assign w_g1  = bus.v1 && (!bus.v0 || !r_lastg);
   assign w_run = (r_state == S_RUN) && !bus.clr;

   // A grant implies the requester's valid is high, so ready is the handshake.
   assign w_hs0 = w_run && w_g0;
   assign w_hs1 = w_run && w_g1;

   assign bus.rdy0      = w_hs0;
   assign bus.rdy1      = w_hs1;
   assign bus.rd        = r_rd;
   assign bus.datawrite = r_datawrite;
   assign bus.Ruwr      = r_ruwr;
   assign bus.dropcnt   = r_dropcnt;
   assign bus.initdone  = (r_state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_datawrite <= '0;
         r_ruwr      <= 1'b0;
         r_lastg     <= 1'b1;
         r_dropcnt   <= '0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (bus.clr) begin
                  // Restart the sweep from index 0 on the next cycle.
                  r_cnt  <= '0;
                  r_ruwr <= 1'b0;
               end else begin
                  r_ruwr      <= 1'b1;
                  r_rd        <= r_cnt;
                  r_datawrite <= '0;
                  if (r_cnt == AW'(NREGS - 1)) begin
                     r_cnt   <= '0;
                     r_state <= S_RUN;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (bus.clr) begin
                  r_state <= S_INIT;
                  r_cnt   <= '0;
                  r_ruwr  <= 1'b0;
               end else if (w_hs0 || w_hs1) begin
                  r_rd        <= w_hs0 ? bus.rd0 : bus.rd1;
                  r_datawrite <= w_hs0 ? bus.data0 : bus.data1;
                  r_lastg     <= w_hs1;
                  // x0 must stay zero: accept the request but do not write.
                  if ((w_hs0 ? bus.rd0 : bus.rd1) == '0) begin
                     r_ruwr <= 1'b0;
                     if (r_dropcnt != 8'hFF) begin
                        r_dropcnt <= r_dropcnt + 8'd1;
                     end
                  end else begin
                     r_ruwr <= 1'b1;
                  end
               end else begin
                  r_ruwr <= 1'b0;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ru_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ru_write_arbiter
// Purpose : Directed bench for ru_write_arbiter. It checks the reset state,
//           the zero sweep, and a table of RUN-mode arbitration vectors. It
//           also covers x0 drop counting and saturation, clr, and reset
//           asserted mid-sweep. A small register-file model is written from
//           the DUT's write port.
// ---------------------------------------------------------------------------
module tb_ru_write_arbiter;

   logic clk;
   logic rst_n;

   ru_write_arbiter_if #(.AW(5), .DW(32)) bus_if ();

   ru_write_arbiter #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model, pre-seeded with a non-zero pattern.
   logic [31:0] regs [32];
   bit          seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'hDEADBEEF;
         seeded <= 1'b1;
      end else if (bus_if.Ruwr) begin
         regs[bus_if.rd] <= bus_if.datawrite;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.clr   = 1'b0;
      bus_if.v0    = 1'b0;
      bus_if.rd0   = '0;
      bus_if.data0 = '0;
      bus_if.v1    = 1'b0;
      bus_if.rd1   = '0;
      bus_if.data1 = '0;
   endtask

   typedef struct {
      logic        v0;
      logic [4:0]  rd0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  rd1;
      logic [31:0] d1;
      logic        e_rdy0;
      logic        e_rdy1;
      logic [4:0]  e_rd;
      logic [31:0] e_dw;
      logic        e_wr;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Watchdog: the bench never waits on DUT events, but guard anyway.
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Fields: v0 rd0 d0 | v1 rd1 d1 | rdy0 rdy1 | rd datawrite Ruwr dropcnt
      // The table starts in RUN with lastg=1, so requester 0 wins the first contention.
      tbl[0]  = '{1'b1, 5'd3,  32'd572264,  1'b1, 5'd4,  32'd342916,  1'b1, 1'b0, 5'd3,  32'd572264,  1'b1, 8'd0};
      tbl[1]  = '{1'b1, 5'd3,  32'd572264,  1'b1, 5'd4,  32'd342916,  1'b0, 1'b1, 5'd4,  32'd342916,  1'b1, 8'd0};
      tbl[2]  = '{1'b1, 5'd3,  32'd572264,  1'b1, 5'd4,  32'd342916,  1'b1, 1'b0, 5'd3,  32'd572264,  1'b1, 8'd0};
      tbl[3]  = '{1'b1, 5'd3,  32'd572264,  1'b1, 5'd4,  32'd342916,  1'b0, 1'b1, 5'd4,  32'd342916,  1'b1, 8'd0};
      tbl[4]  = '{1'b0, 5'd0,  32'd0,       1'b0, 5'd0,  32'd0,       1'b0, 1'b0, 5'd4,  32'd342916,  1'b0, 8'd0};
      tbl[5]  = '{1'b1, 5'd5,  32'd481184,  1'b0, 5'd0,  32'd0,       1'b1, 1'b0, 5'd5,  32'd481184,  1'b1, 8'd0};
      tbl[6]  = '{1'b0, 5'd0,  32'd0,       1'b1, 5'd0,  32'd1234673, 1'b0, 1'b1, 5'd0,  32'd1234673, 1'b0, 8'd1};
      tbl[7]  = '{1'b1, 5'd9,  32'h11,      1'b1, 5'd10, 32'h22,      1'b1, 1'b0, 5'd9,  32'h11,      1'b1, 8'd1};
      tbl[8]  = '{1'b1, 5'd9,  32'h33,      1'b0, 5'd0,  32'd0,       1'b1, 1'b0, 5'd9,  32'h33,      1'b1, 8'd1};
      tbl[9]  = '{1'b1, 5'd9,  32'h44,      1'b1, 5'd10, 32'h22,      1'b0, 1'b1, 5'd10, 32'h22,      1'b1, 8'd1};
      tbl[10] = '{1'b1, 5'd0,  32'd5,       1'b0, 5'd0,  32'd0,       1'b1, 1'b0, 5'd0,  32'd5,       1'b0, 8'd2};
      tbl[11] = '{1'b1, 5'd0,  32'd6,       1'b1, 5'd12, 32'd7,       1'b0, 1'b1, 5'd12, 32'd7,       1'b1, 8'd2};

      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // ---- Reset state ----
      check("rst_Ruwr",     bus_if.Ruwr, 0);
      check("rst_rd",       bus_if.rd, 0);
      check("rst_dw",       bus_if.datawrite, 0);
      check("rst_initdone", bus_if.initdone, 0);
      check("rst_dropcnt",  bus_if.dropcnt, 0);
      rst_n = 1'b1;

      // ---- Zero sweep after reset ----
      for (int i = 0; i < 32; i++) begin
         tick();
         check($sformatf("init_Ruwr[%0d]", i), bus_if.Ruwr, 1);
         check($sformatf("init_rd[%0d]", i), bus_if.rd, i);
         check($sformatf("init_dw[%0d]", i), bus_if.datawrite, 0);
         check($sformatf("init_done[%0d]", i), bus_if.initdone, (i == 31) ? 1 : 0);
      end
      tick();
      check("post_init_Ruwr", bus_if.Ruwr, 0);
      check("post_init_done", bus_if.initdone, 1);
      for (int r = 1; r < 32; r++) check($sformatf("zero_r%0d", r), regs[r], 0);

      // ---- Table-driven RUN vectors ----
      for (int k = 0; k < 12; k++) begin
         bus_if.v0    = tbl[k].v0;
         bus_if.rd0   = tbl[k].rd0;
         bus_if.data0 = tbl[k].d0;
         bus_if.v1    = tbl[k].v1;
         bus_if.rd1   = tbl[k].rd1;
         bus_if.data1 = tbl[k].d1;
         #1;
         check($sformatf("vec%0d_rdy0", k), bus_if.rdy0, tbl[k].e_rdy0);
         check($sformatf("vec%0d_rdy1", k), bus_if.rdy1, tbl[k].e_rdy1);
         tick();
         check($sformatf("vec%0d_rd", k), bus_if.rd, tbl[k].e_rd);
         check($sformatf("vec%0d_dw", k), bus_if.datawrite, tbl[k].e_dw);
         check($sformatf("vec%0d_Ruwr", k), bus_if.Ruwr, tbl[k].e_wr);
         check($sformatf("vec%0d_dropcnt", k), bus_if.dropcnt, tbl[k].e_drop);
      end
      idle_inputs();
      tick();
      check("rf_r0",  regs[0],  0);
      check("rf_r3",  regs[3],  572264);
      check("rf_r4",  regs[4],  342916);
      check("rf_r5",  regs[5],  481184);
      check("rf_r9",  regs[9],  32'h33);
      check("rf_r10", regs[10], 32'h22);
      check("rf_r12", regs[12], 7);

      // ---- dropcnt saturation: 2 + 253 = 255, then stays at 255 ----
      bus_if.v0  = 1'b1;
      bus_if.rd0 = 5'd0;
      repeat (253) tick();
      check("drop_reach_255", bus_if.dropcnt, 255);
      repeat (5) tick();
      check("drop_saturated", bus_if.dropcnt, 255);
      check("drop_no_write",  bus_if.Ruwr, 0);

      // ---- clr while requester 0 is pending ----
      bus_if.rd0   = 5'd20;
      bus_if.data0 = 32'hABCD;
      bus_if.clr   = 1'b1;
      #1;
      check("clr_rdy0", bus_if.rdy0, 0);
      tick();
      bus_if.clr = 1'b0;
      check("clr_Ruwr",     bus_if.Ruwr, 0);
      check("clr_initdone", bus_if.initdone, 0);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("clr_sweep_rdy0[%0d]", i), bus_if.rdy0, 0);
         tick();
         check($sformatf("clr_sweep_rd[%0d]", i), bus_if.rd, i);
         check($sformatf("clr_sweep_wr[%0d]", i), bus_if.Ruwr, 1);
         check($sformatf("clr_sweep_dw[%0d]", i), bus_if.datawrite, 0);
      end
      check("clr_first_run_rdy0", bus_if.rdy0, 1);
      tick();
      bus_if.v0 = 1'b0;
      check("clr_pending_rd",   bus_if.rd, 20);
      check("clr_pending_dw",   bus_if.datawrite, 32'hABCD);
      check("clr_pending_Ruwr", bus_if.Ruwr, 1);
      check("clr_r3_zeroed",    regs[3], 0);
      tick();
      check("clr_r20_written",  regs[20], 32'hABCD);

      // ---- reset asserted mid-sweep at cnt=10 ----
      bus_if.clr = 1'b1;
      tick();
      bus_if.clr = 1'b0;
      repeat (10) tick();
      check("pre_rst_rd", bus_if.rd, 9);
      rst_n = 1'b0;
      #1;
      check("midrst_Ruwr",    bus_if.Ruwr, 0);
      check("midrst_rd",      bus_if.rd, 0);
      check("midrst_dw",      bus_if.datawrite, 0);
      check("midrst_dropcnt", bus_if.dropcnt, 0);
      check("midrst_done",    bus_if.initdone, 0);
      #2;
      rst_n = 1'b1;
      tick();
      check("rerun_rd0",   bus_if.rd, 0);
      check("rerun_wr0",   bus_if.Ruwr, 1);
      tick();
      check("rerun_rd1",   bus_if.rd, 1);

      // ---- clr during the sweep restarts it at 0 ----
      bus_if.clr = 1'b1;
      #1;
      check("init_clr_rdy0", bus_if.rdy0, 0);
      tick();
      bus_if.clr = 1'b0;
      check("init_clr_Ruwr", bus_if.Ruwr, 0);
      tick();
      check("init_clr_rd",   bus_if.rd, 0);
      check("init_clr_wr",   bus_if.Ruwr, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
